// File: rtl/trng_bit_source.sv
// TRNG bit producer: synchronises a raw entropy line, samples it on a divider, optionally pairs samples
// through a von Neumann extractor (macro TRNG_VN_DEBIAS_EN), presents one bit per ACK, and runs a repetition-count health test.
module trng_bit_source #(
    parameter int SAMPLE_DIV = 8,
    parameter int REP_LIMIT  = 32
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic EN,
    input  logic ENTROPY,
    input  logic ACK,
    output logic RANDOM,
    output logic BIT_READY,
    output logic FAULT
);

`ifdef TRNG_VN_DEBIAS_EN
    typedef enum logic [1:0] {IDLE, SAMPLE_A, SAMPLE_B, PRESENT} state_t;
`else
    typedef enum logic [1:0] {IDLE, SAMPLE_A, PRESENT} state_t;
`endif

    localparam logic [7:0] DIV_LAST = 8'(SAMPLE_DIV - 1);
    localparam logic [7:0] REP_MAX  = 8'(REP_LIMIT);

    state_t     state;
    state_t     state_next;
    logic       sync1;
    logic       raw;
    logic [7:0] div;
    logic [7:0] div_next;
    logic [7:0] div_step;
    logic [7:0] rep_cnt;
    logic [7:0] rep_next;
    logic       prev_sample;
    logic       random_next;
    logic       bit_ready_next;
    logic       in_sample;
    logic       take;
    logic       trip;
`ifdef TRNG_VN_DEBIAS_EN
    logic       pair_a;
    logic       pair_a_next;
`endif

`ifdef TRNG_VN_DEBIAS_EN
    assign in_sample = (state == SAMPLE_A) || (state == SAMPLE_B);
`else
    assign in_sample = (state == SAMPLE_A);
`endif

    // A sample only counts when the block is actually allowed to run on this edge.
    assign take     = in_sample && EN && !FAULT && (div == DIV_LAST);
    assign div_step = (div == DIV_LAST) ? 8'd0 : div + 8'd1;

    always_comb begin
        rep_next = 8'd1;
        if (rep_cnt != 8'd0 && raw == prev_sample) begin
            rep_next = (rep_cnt >= REP_MAX) ? REP_MAX : rep_cnt + 8'd1;
        end
    end

    assign trip = take && (rep_next >= REP_MAX);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        div_next       = div;
        random_next    = RANDOM;
        bit_ready_next = BIT_READY;
`ifdef TRNG_VN_DEBIAS_EN
        pair_a_next    = pair_a;
`endif
        if (!EN || FAULT || trip) begin
            state_next     = IDLE;
            div_next       = 8'd0;
            bit_ready_next = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_next = SAMPLE_A;
                    div_next   = 8'd0;
                end
                SAMPLE_A: begin
                    div_next = div_step;
                    if (take) begin
`ifdef TRNG_VN_DEBIAS_EN
                        pair_a_next = raw;
                        state_next  = SAMPLE_B;
`else
                        random_next    = raw;
                        bit_ready_next = 1'b1;
                        state_next     = PRESENT;
`endif
                    end
                end
`ifdef TRNG_VN_DEBIAS_EN
                SAMPLE_B: begin
                    div_next = div_step;
                    if (take) begin
                        if (raw != pair_a) begin
                            random_next    = pair_a;
                            bit_ready_next = 1'b1;
                            state_next     = PRESENT;
                        end else begin
                            state_next = SAMPLE_A;
                        end
                    end
                end
`endif
                PRESENT: begin
                    // Divider holds so the next bit is always a full sample period away.
                    if (ACK) begin
                        bit_ready_next = 1'b0;
                        state_next     = SAMPLE_A;
                    end
                end
                default: begin
                    state_next     = IDLE;
                    div_next       = 8'd0;
                    bit_ready_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1       <= 1'b0;
            raw         <= 1'b0;
            div         <= 8'd0;
            rep_cnt     <= 8'd0;
            prev_sample <= 1'b0;
            RANDOM      <= 1'b0;
            BIT_READY   <= 1'b0;
            FAULT       <= 1'b0;
`ifdef TRNG_VN_DEBIAS_EN
            pair_a      <= 1'b0;
`endif
        end else begin
            sync1     <= ENTROPY;
            raw       <= sync1;
            div       <= div_next;
            RANDOM    <= random_next;
            BIT_READY <= bit_ready_next;
`ifdef TRNG_VN_DEBIAS_EN
            pair_a    <= pair_a_next;
`endif
            // Health test sees every sample, including pairs the extractor throws away.
            if (take) begin
                prev_sample <= raw;
                rep_cnt     <= rep_next;
            end
            if (trip) begin
                FAULT <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trng_bit_source.sv
// Scoreboard bench for trng_bit_source: expected bits are queued as entropy is driven and checked
// when BIT_READY rises; adapts to the TRNG_VN_DEBIAS_EN build.
module tb_trng_bit_source;
    localparam int SAMPLE_DIV = 4;
    localparam int REP_LIMIT  = 32;
`ifdef TRNG_VN_DEBIAS_EN
    localparam int NSAMP = 2;
`else
    localparam int NSAMP = 1;
`endif

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic EN = 1'b0;
    logic ENTROPY = 1'b0;
    logic ACK = 1'b0;
    logic RANDOM;
    logic BIT_READY;
    logic FAULT;

    int tests = 0;
    int fails = 0;
    logic exp_q[$];

    trng_bit_source #(.SAMPLE_DIV(SAMPLE_DIV), .REP_LIMIT(REP_LIMIT)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .EN(EN),
        .ENTROPY(ENTROPY),
        .ACK(ACK),
        .RANDOM(RANDOM),
        .BIT_READY(BIT_READY),
        .FAULT(FAULT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        EN = 1'b0;
        ACK = 1'b0;
        ENTROPY = 1'b0;
        exp_q.delete();
        tick();
        tick();
        RST_N = 1'b1;
        tick();
    endtask

    // EN is sampled on the next edge, which moves the DUT into SAMPLE_A.
    task automatic start_run();
        EN = 1'b1;
        tick();
    endtask

    // Called just after the edge that entered SAMPLE_A; drives entropy so the next bit is v.
    task automatic produce(input logic v, input string name);
        int lat;
        logic exp;
        exp_q.push_back(v);
        ENTROPY = v;
        lat = 0;
`ifdef TRNG_VN_DEBIAS_EN
        repeat (SAMPLE_DIV) tick();
        ENTROPY = ~v;
        lat = SAMPLE_DIV;
`endif
        while (!BIT_READY && lat < NSAMP * SAMPLE_DIV + 8) begin
            tick();
            lat++;
        end
        tests++;
        if (!BIT_READY || lat != NSAMP * SAMPLE_DIV) begin
            fails++;
            $display("FAIL %s latency: got %0d edges (ready=%b), required %0d", name, lat, BIT_READY,
                     NSAMP * SAMPLE_DIV);
        end
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s scoreboard: bit presented with no expected value queued", name);
        end else begin
            exp = exp_q.pop_front();
            if (RANDOM !== exp) begin
                fails++;
                $display("FAIL %s random: got %b, required %b", name, RANDOM, exp);
            end
        end
    endtask

    task automatic accept(input string name);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        tests++;
        if (BIT_READY !== 1'b0) begin
            fails++;
            $display("FAIL %s ack_drop: BIT_READY got %b, required 0", name, BIT_READY);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        EN = 1'b0;
        tick();
        tick();
        tests++;
        if (RANDOM !== 1'b0) begin fails++; $display("FAIL reset_random: got %b, required 0", RANDOM); end
        tests++;
        if (BIT_READY !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b, required 0", BIT_READY); end
        tests++;
        if (FAULT !== 1'b0) begin fails++; $display("FAIL reset_fault: got %b, required 0", FAULT); end
        RST_N = 1'b1;
        repeat (3 * SAMPLE_DIV) tick();
        tests++;
        if (BIT_READY !== 1'b0) begin fails++; $display("FAIL idle_no_bit: got %b, required 0", BIT_READY); end
    endtask

    task automatic test_bits();
        do_reset();
        start_run();
        produce(1'b0, "bits0");
        accept("bits0");
        produce(1'b1, "bits1");
        accept("bits1");
        produce(1'b0, "bits2");
        accept("bits2");
        produce(1'b1, "bits3");
        accept("bits3");
        tests++;
        if (FAULT !== 1'b0) begin fails++; $display("FAIL bits_fault: got %b, required 0", FAULT); end
    endtask

`ifdef TRNG_VN_DEBIAS_EN
    task automatic test_discard();
        int early;
        do_reset();
        start_run();
        ENTROPY = 1'b1;
        early = 0;
        repeat (2 * SAMPLE_DIV) begin
            tick();
            if (BIT_READY !== 1'b0) early++;
        end
        tests++;
        if (early != 0) begin
            fails++;
            $display("FAIL discard_equal_pair: BIT_READY high on %0d edges, required 0", early);
        end
        produce(1'b0, "discard_next");
        accept("discard_next");
    endtask
`endif

    task automatic test_ack_hold();
        int bad;
        do_reset();
        start_run();
        produce(1'b1, "hold");
        ENTROPY = 1'b1;
        bad = 0;
        repeat (140) begin
            tick();
            if (BIT_READY !== 1'b1 || RANDOM !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL hold_stable: %0d unstable edges, required 0", bad);
        end
        tests++;
        if (FAULT !== 1'b0) begin fails++; $display("FAIL hold_no_sampling: FAULT got %b, required 0", FAULT); end
        accept("hold");
        produce(1'b0, "hold_next");
        accept("hold_next");
    endtask

    task automatic test_en_drop();
        int bad;
        do_reset();
        start_run();
        produce(1'b1, "endrop");
        EN = 1'b0;
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        tests++;
        if (BIT_READY !== 1'b0) begin fails++; $display("FAIL endrop_ready: got %b, required 0", BIT_READY); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            ENTROPY = i[0];
            tick();
            if (BIT_READY !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL endrop_idle: %0d edges with BIT_READY, required 0", bad); end
        start_run();
        produce(1'b0, "endrop_resume");
        accept("endrop_resume");
    endtask

    task automatic test_fault();
        int lat;
        int bad;
        int exp_lat;
`ifdef TRNG_VN_DEBIAS_EN
        exp_lat = REP_LIMIT * SAMPLE_DIV;
`else
        exp_lat = SAMPLE_DIV + (REP_LIMIT - 1) * (SAMPLE_DIV + 1);
`endif
        do_reset();
        ENTROPY = 1'b1;
`ifndef TRNG_VN_DEBIAS_EN
        ACK = 1'b1;
`endif
        start_run();
        lat = 0;
        bad = 0;
        while (FAULT !== 1'b1 && lat < 400) begin
            tick();
            lat++;
`ifdef TRNG_VN_DEBIAS_EN
            if (BIT_READY !== 1'b0) bad++;
`else
            if (BIT_READY === 1'b1 && RANDOM !== 1'b1) bad++;
`endif
        end
        ACK = 1'b0;
        tests++;
        if (FAULT !== 1'b1 || lat != exp_lat) begin
            fails++;
            $display("FAIL fault_latency: got %0d edges (fault=%b), required %0d", lat, FAULT, exp_lat);
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL fault_bits: %0d bad presented bits, required 0", bad); end
        bad = 0;
        for (int r = 0; r < 2; r++) begin
            EN = 1'b0;
            repeat (3) tick();
            EN = 1'b1;
            for (int i = 0; i < 3 * SAMPLE_DIV; i++) begin
                ENTROPY = i[1];
                tick();
                if (FAULT !== 1'b1 || BIT_READY !== 1'b0) bad++;
            end
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL fault_sticky: %0d bad edges, required 0", bad); end
        #3;
        RST_N = 1'b0;
        #1;
        tests++;
        if (FAULT !== 1'b0) begin fails++; $display("FAIL fault_clear: got %b, required 0", FAULT); end
        EN = 1'b0;
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_present();
        do_reset();
        start_run();
        produce(1'b1, "midrst");
        #3;
        RST_N = 1'b0;
        #1;
        tests++;
        if (BIT_READY !== 1'b0 || RANDOM !== 1'b0 || FAULT !== 1'b0) begin
            fails++;
            $display("FAIL midrst_async: ready=%b random=%b fault=%b, required all 0", BIT_READY, RANDOM, FAULT);
        end
        exp_q.delete();
        #1;
        RST_N = 1'b1;
        tick();
        produce(1'b0, "midrst_restart");
        accept("midrst_restart");
    endtask

    initial begin
        test_reset();
        test_bits();
`ifdef TRNG_VN_DEBIAS_EN
        test_discard();
`endif
        test_ack_hold();
        test_en_drop();
        test_fault();
        test_reset_mid_present();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
